// File: rtl/ifetch_buffer.sv
// rtl/ifetch_buffer.sv - fetch PC owner, imem request issue, in-order response FIFO, redirect drain
// Optional feature macro IFETCH_MISALIGN_TRAP_EN: misaligned redirect sets sticky fetch_misaligned and halts fetch.
module ifetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          req_valid_q, req_valid_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   instr_pc_q, instr_pc_d;
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];

  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] remain;
  logic          halt_d;

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (count_q != '0);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  assign fetch_misaligned = mis_q;
  assign mis_d  = redirect_valid ? (redirect_pc[1:0] != 2'b00) : mis_q;
  assign halt_d = mis_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
`else
  assign halt_d = 1'b0;
`endif

  always_comb begin
    accept = req_valid_q && imem_req_ready;
    pop    = instr_valid && instr_ready;
    push   = imem_rsp_valid && (state_q == FETCH) && !redirect_valid;
    // Outstanding requests are consecutive words, so the oldest one sits outst_q words behind pc_q.
    rsp_pc = pc_q - {{(30-CW){1'b0}}, outst_q, 2'b00};

    outst_d = outst_q + CW'(accept) - CW'(imem_rsp_valid);

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (accept) begin
      pc_d = pc_q + 32'd4;
    end

    state_d = state_q;
    if (redirect_valid || (state_q == DRAIN)) begin
      state_d = (outst_d != '0) ? DRAIN : FETCH;
    end

    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
    end

    // Output registers track the next head; when the FIFO empties they keep the last word shown.
    remain     = count_q - CW'(pop);
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (count_d != '0) begin
      if (remain == '0) begin
        instr_d    = imem_rsp_data;
        instr_pc_d = rsp_pc;
      end else begin
        instr_d    = mem_data_q[rd_ptr_d];
        instr_pc_d = mem_pc_q[rd_ptr_d];
      end
    end

    req_valid_d = (state_d == FETCH) && !halt_d &&
                  (({1'b0, count_d} + {1'b0, outst_d}) < DEPTH_W);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= imem_rsp_data;
      mem_pc_q[wr_ptr_q]   <= rsp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC & 32'hFFFF_FFFC;
      outst_q     <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      req_valid_q <= 1'b0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      outst_q     <= outst_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      req_valid_q <= req_valid_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CW'(DEPTH))));

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (outst_q == '0)));

endmodule

// File: tb/tb_ifetch_buffer.sv
// tb/tb_ifetch_buffer.sv - directed self-checking bench for ifetch_buffer
module tb_ifetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  ifetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int lat;
  int first_iv;
  logic [31:0] acc_log[$];
  int          acc_cyc[$];
  logic [31:0] got_instr[$];
  logic [31:0] got_pc[$];
  logic [31:0] pend_addr[$];
  int          pend_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: observe handshakes mid-cycle, then present the memory response for the new cycle.
  task automatic tick();
    logic        acc_now, pop_now;
    logic [31:0] a, pi, pp;
    @(negedge clk);
    acc_now = imem_req_valid && imem_req_ready;
    a       = imem_req_addr;
    pop_now = instr_valid && instr_ready;
    pi      = instr;
    pp      = instr_pc;
    if (instr_valid && first_iv < 0) first_iv = cyc;
    @(posedge clk);
    #1;
    if (acc_now) begin
      acc_log.push_back(a);
      acc_cyc.push_back(cyc);
      pend_addr.push_back(a);
      pend_cyc.push_back(cyc);
    end
    if (pop_now) begin
      got_instr.push_back(pi);
      got_pc.push_back(pp);
    end
    cyc++;
    redirect_valid = 1'b0;
    if (pend_addr.size() > 0 && (cyc - pend_cyc[0]) >= lat) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_cyc.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    #1;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_log.delete();
    acc_cyc.delete();
    got_instr.delete();
    got_pc.delete();
    pend_addr.delete();
    pend_cyc.delete();
    cyc      = 0;
    first_iv = -1;
    lat      = 1;
  endtask

  initial begin
    // Streaming with a 1-cycle memory.
    do_reset();
    ticks(12);
    check("t1_acc0", acc_log[0], 32'h0);
    check("t1_acc1", acc_log[1], 32'h4);
    check("t1_acc2", acc_log[2], 32'h8);
    check("t1_acc3", acc_log[3], 32'hC);
    check("t1_acc_b2b", acc_cyc[3], acc_cyc[0] + 3);
    check("t1_first_lat", first_iv - acc_cyc[0], 32'd2);
    check("t1_n_instr", got_pc.size(), 32'd9);
    check("t1_pc0", got_pc[0], 32'h0);
    check("t1_pc1", got_pc[1], 32'h4);
    check("t1_pc3", got_pc[3], 32'hC);
    check("t1_instr2", got_instr[2], mem_word(32'h8));

    // Backpressure fills DEPTH entries; one pop frees exactly one request slot.
    do_reset();
    instr_ready = 1'b0;
    ticks(10);
    check("t2_n_acc", acc_log.size(), 32'd4);
    check("t2_req_idle", {31'b0, imem_req_valid}, 32'd0);
    check("t2_head_valid", {31'b0, instr_valid}, 32'd1);
    check("t2_head_pc", instr_pc, 32'h0);
    check("t2_head_instr", instr, mem_word(32'h0));
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("t2_n_pop", got_pc.size(), 32'd1);
    check("t2_req_again", {31'b0, imem_req_valid}, 32'd1);
    check("t2_req_addr", imem_req_addr, 32'h10);
    check("t2_next_head", instr_pc, 32'h4);
    ticks(5);
    check("t2_n_acc2", acc_log.size(), 32'd5);
    check("t2_acc4_cyc", acc_cyc[4], 32'd11);
    check("t2_req_idle2", {31'b0, imem_req_valid}, 32'd0);

    // Redirect with three requests in flight on a 3-cycle memory.
    do_reset();
    lat = 3;
    ticks(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    check("t3_drain_noreq", {31'b0, imem_req_valid}, 32'd0);
    ticks(12);
    check("t3_n_old", acc_log.size() >= 3 ? acc_log[2] : 32'hDEAD, 32'h8);
    check("t3_new_addr", acc_log[3], 32'h100);
    check("t3_new_cyc", acc_cyc[3], 32'd7);
    check("t3_first_pc", got_pc[0], 32'h100);
    check("t3_first_instr", got_instr[0], mem_word(32'h100));

    // Redirect coinciding with a response and a decode handshake.
    do_reset();
    ticks(3);
    check("t4_pre_valid", {31'b0, instr_valid}, 32'd1);
    check("t4_pre_rsp", {31'b0, imem_rsp_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    check("t4_flushed", {31'b0, instr_valid}, 32'd0);
    check("t4_n_pop", got_pc.size(), 32'd1);
    ticks(8);
    check("t4_pc0", got_pc[0], 32'h0);
    check("t4_pc1", got_pc[1], 32'h40);
    check("t4_instr1", got_instr[1], mem_word(32'h40));
    check("t4_new_addr", acc_log[3], 32'h40);
    check("t4_new_cyc", acc_cyc[3], 32'd5);

    // Address wrap at the top of the 32-bit space.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    ticks(6);
    check("t5_acc0", acc_log[0], 32'hFFFF_FFF8);
    check("t5_acc1", acc_log[1], 32'hFFFF_FFFC);
    check("t5_acc2", acc_log[2], 32'h0000_0000);
    check("t5_pc1", got_pc[1], 32'hFFFF_FFFC);
    check("t5_pc2", got_pc[2], 32'h0000_0000);

    // Misaligned redirect target.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
`ifdef IFETCH_MISALIGN_TRAP_EN
    tick();
    check("t6_mis_set", {31'b0, fetch_misaligned}, 32'd1);
    ticks(5);
    check("t6_no_req", acc_log.size(), 32'd0);
    check("t6_req_idle", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    check("t6_mis_clr", {31'b0, fetch_misaligned}, 32'd0);
    ticks(5);
    check("t6_resume", acc_log[0], 32'h200);
    check("t6_pc0", got_pc[0], 32'h200);
`else
    ticks(6);
    check("t6_forced_align", acc_log[0], 32'h100);
    check("t6_pc0", got_pc[0], 32'h100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
